// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction RAM in front of the CPU fetch port.
// After reset it loads a big-endian byte image over a valid/ready port.
// While it loads it holds the CPU in reset. When the image is complete
// it releases the CPU and answers fetches combinationally.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   ld_valid/ld_data/ld_last/ld_ready   byte load handshake
//   reload          one-cycle request to reload the image (RUN only)
//   rom_ce/rom_addr/rom_data_o          CPU fetch port (data is combinational)
//   cpu_rst_o       CPU reset, high until the image is loaded
//   load_done_o     image loaded, CPU running
//   word_cnt_o      number of words written
//   err_o           sticky error: truncated last word or overflow
module inst_rom_loader #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic          rom_ce,
  input  logic [31:0]   rom_addr,
  output logic [31:0]   rom_data_o,
  output logic          cpu_rst_o,
  output logic          load_done_o,
  output logic [AW:0]   word_cnt_o,
  output logic          err_o
);

  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          r_ld_ready;
  logic          r_cpu_rst;
  logic          r_load_done;
  logic [AW:0]   r_word_cnt;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_shift;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_acc;
  logic          w_full;
  logic          w_wr;
  logic          w_reload;
  logic [31:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_hit;
  logic          w_unused;

  // A byte can only be accepted in LOAD, since ld_ready mirrors that state.
  assign w_acc    = ld_valid && r_ld_ready;
  assign w_full   = (r_word_cnt == (AW+1)'(DEPTH));
  assign w_wr     = w_acc && !w_full && ((r_bcnt == 2'd3) || ld_last);
  assign w_reload = (r_state == S_RUN) && reload;

  // Current word: earlier bytes from the shift register, the incoming byte in
  // its lane, unfilled low lanes zero so a truncated final word is padded.
  always_comb begin
    w_word = 32'd0;
    case (r_bcnt)
      2'd0:    w_word = {ld_data, 24'd0};
      2'd1:    w_word = {r_shift[23:16], ld_data, 16'd0};
      2'd2:    w_word = {r_shift[23:8], ld_data, 8'd0};
      default: w_word = {r_shift, ld_data};
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_LOAD;
      S_LOAD: if (w_acc && ld_last) w_next = S_RUN;
      S_RUN:  if (reload) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered state-decoded outputs, updated on the edge entering a state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_ready  <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      r_ld_ready  <= (w_next == S_LOAD);
      r_cpu_rst   <= (w_next != S_RUN);
      r_load_done <= (w_next == S_RUN);
    end
  end

  // Byte lane counter, word counter, shift register and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_bcnt     <= 2'd0;
      r_shift    <= 24'd0;
      r_err      <= 1'b0;
    end else if (w_reload) begin
      r_word_cnt <= '0;
      r_bcnt     <= 2'd0;
      r_err      <= 1'b0;
    end else if (w_acc) begin
      if (w_full) begin
        r_err <= 1'b1;
      end else begin
        r_shift <= w_word[31:8];
        if (w_wr) begin
          r_word_cnt <= r_word_cnt + (AW+1)'(1);
          r_bcnt     <= 2'd0;
          if (r_bcnt != 2'd3) r_err <= 1'b1;
        end else begin
          r_bcnt <= r_bcnt + 2'd1;
        end
      end
    end
  end

  // Instruction RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_word_cnt[AW-1:0]] <= w_word;
  end

  // Fetch: upper address bits alias, unwritten words and non-RUN read as 0.
  assign w_idx      = rom_addr[AW+1:2];
  assign w_hit      = (r_state == S_RUN) && rom_ce && ({1'b0, w_idx} < r_word_cnt);
  assign rom_data_o = w_hit ? r_mem[w_idx] : 32'd0;
  assign w_unused   = &{1'b0, rom_addr[31:AW+2], rom_addr[1:0]};

  assign ld_ready    = r_ld_ready;
  assign cpu_rst_o   = r_cpu_rst;
  assign load_done_o = r_load_done;
  assign word_cnt_o  = r_word_cnt;
  assign err_o       = r_err;

endmodule
